// File: rtl/war_round_scorer_if.sv
// Round request and score/status bundle between a dealer and the War scoring core.
interface war_round_scorer_if;
    logic       deal;
    logic [3:0] card_p1;
    logic [3:0] card_p2;
    logic [3:0] score_p1;
    logic [3:0] score_p2;
    logic [1:0] winner;
    logic [3:0] pot;
    logic       war_pending;
    logic       busy;
    logic       err;
    logic       game_over;

    modport master (
        output deal, card_p1, card_p2,
        input  score_p1, score_p2, winner, pot, war_pending, busy, err, game_over
    );

    modport slave (
        input  deal, card_p1, card_p2,
        output score_p1, score_p2, winner, pot, war_pending, busy, err, game_over
    );
endinterface

// File: rtl/war_round_scorer.sv
// War card-game round scorer: compares one card per player, grows a pot on ties,
// awards the pot to the next round winner and stops once a score reaches WIN_SCORE.
module war_round_scorer #(
    parameter int WIN_SCORE = 15,
    parameter int MAX_RANK  = 12
) (
    input logic               clk,
    input logic               resetn,
    war_round_scorer_if.slave bus
);
    typedef enum logic [1:0] {IDLE, CMP, AWARD, DONE} state_t;

    localparam logic [4:0] WIN5 = 5'(WIN_SCORE);
    localparam logic [3:0] MAX4 = 4'(MAX_RANK);

    state_t     state_reg;
    logic [3:0] card_reg  [2];
    logic [3:0] score_reg [2];
    logic [3:0] award_score [2];
    logic [1:0] winner_reg;
    logic [3:0] pot_reg;
    logic       war_reg;
    logic       err_reg;
    logic       over_reg;

    // Sum at 5 bits so a large pot cannot wrap before saturation.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_award
            logic [4:0] sum;
            assign sum             = {1'b0, score_reg[gi]} + {1'b0, pot_reg};
            assign award_score[gi] = (sum >= WIN5) ? WIN5[3:0] : sum[3:0];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_reg    <= IDLE;
            card_reg[0]  <= 4'd0;
            card_reg[1]  <= 4'd0;
            score_reg[0] <= 4'd0;
            score_reg[1] <= 4'd0;
            winner_reg   <= 2'b00;
            pot_reg      <= 4'd1;
            war_reg      <= 1'b0;
            err_reg      <= 1'b0;
            over_reg     <= 1'b0;
        end else begin
            err_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (bus.deal) begin
                        card_reg[0] <= bus.card_p1;
                        card_reg[1] <= bus.card_p2;
                        state_reg   <= CMP;
                    end
                end
                CMP: begin
                    if ((card_reg[0] > MAX4) || (card_reg[1] > MAX4)) begin
                        err_reg   <= 1'b1;
                        state_reg <= IDLE;
                    end else if (card_reg[0] == card_reg[1]) begin
                        winner_reg <= 2'b11;
                        war_reg    <= 1'b1;
                        if (pot_reg != 4'hF) begin
                            pot_reg <= pot_reg + 4'd1;
                        end
                        state_reg <= IDLE;
                    end else begin
                        winner_reg <= (card_reg[0] > card_reg[1]) ? 2'b01 : 2'b10;
                        state_reg  <= AWARD;
                    end
                end
                AWARD: begin
                    // winner_reg[1] selects player 2 (10) versus player 1 (01).
                    score_reg[winner_reg[1]] <= award_score[winner_reg[1]];
                    pot_reg <= 4'd1;
                    war_reg <= 1'b0;
                    if (award_score[winner_reg[1]] == WIN5[3:0]) begin
                        over_reg  <= 1'b1;
                        state_reg <= DONE;
                    end else begin
                        state_reg <= IDLE;
                    end
                end
                DONE: begin
                    state_reg <= DONE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.score_p1    = score_reg[0];
    assign bus.score_p2    = score_reg[1];
    assign bus.winner      = winner_reg;
    assign bus.pot         = pot_reg;
    assign bus.war_pending = war_reg;
    assign bus.err         = err_reg;
    assign bus.game_over   = over_reg;
    assign bus.busy        = (state_reg != IDLE);
endmodule

// File: tb/tb_war_round_scorer.sv
// Scoreboard bench for war_round_scorer: an independent game model queues the
// expected result of each dealt round, compared once the round's window has elapsed.
module tb_war_round_scorer;
    logic clk = 1'b0;
    logic resetn;

    war_round_scorer_if bus();

    war_round_scorer #(.WIN_SCORE(15), .MAX_RANK(12)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        int winner;
        int err_n;
        int busy_n;
        int s1;
        int s2;
        int pot;
        int war;
        int over;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   round_no = 0;

    int m_s1, m_s2, m_pot, m_war, m_over, m_winner;

    task automatic check_eq(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_s1 = 0; m_s2 = 0; m_pot = 1; m_war = 0; m_over = 0; m_winner = 0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, ".score_p1"}, int'(bus.score_p1), 0);
        check_eq({tag, ".score_p2"}, int'(bus.score_p2), 0);
        check_eq({tag, ".winner"}, int'(bus.winner), 0);
        check_eq({tag, ".pot"}, int'(bus.pot), 1);
        check_eq({tag, ".war_pending"}, int'(bus.war_pending), 0);
        check_eq({tag, ".busy"}, int'(bus.busy), 0);
        check_eq({tag, ".err"}, int'(bus.err), 0);
        check_eq({tag, ".game_over"}, int'(bus.game_over), 0);
    endtask

    // Predict one round from the game rules and push it to the scoreboard.
    task automatic predict(input int c1, input int c2);
        exp_t e;
        int   sum;
        e.err_n = 0;
        if (m_over != 0) begin
            e.busy_n = 4;
        end else if (c1 > 12 || c2 > 12) begin
            e.err_n  = 1;
            e.busy_n = 1;
        end else if (c1 == c2) begin
            m_winner = 3;
            m_war    = 1;
            m_pot    = (m_pot + 1 > 15) ? 15 : m_pot + 1;
            e.busy_n = 1;
        end else begin
            m_winner = (c1 > c2) ? 1 : 2;
            if (m_winner == 1) begin
                sum  = m_s1 + m_pot;
                m_s1 = (sum > 15) ? 15 : sum;
                if (m_s1 == 15) m_over = 1;
            end else begin
                sum  = m_s2 + m_pot;
                m_s2 = (sum > 15) ? 15 : sum;
                if (m_s2 == 15) m_over = 1;
            end
            m_pot    = 1;
            m_war    = 0;
            e.busy_n = (m_over != 0) ? 4 : 2;
        end
        e.winner = m_winner;
        e.s1     = m_s1;
        e.s2     = m_s2;
        e.pot    = m_pot;
        e.war    = m_war;
        e.over   = m_over;
        sb.push_back(e);
    endtask

    // Deal one round, poke junk deal/cards while busy, observe a 4-cycle window.
    task automatic play(input int c1, input int c2);
        exp_t e;
        int busy_n = 0, err_n = 0, win_n2 = 0, s1_n3 = 0, s2_n3 = 0;
        string t;
        predict(c1, c2);
        round_no++;
        t = $sformatf("r%0d(%0d/%0d)", round_no, c1, c2);
        @(negedge clk);
        bus.deal    = 1'b1;
        bus.card_p1 = 4'(c1);
        bus.card_p2 = 4'(c2);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            busy_n += int'(bus.busy);
            err_n  += int'(bus.err);
            if (k == 2) win_n2 = int'(bus.winner);
            if (k == 3) begin
                s1_n3 = int'(bus.score_p1);
                s2_n3 = int'(bus.score_p2);
            end
            if (k == 1) begin
                bus.card_p1 = 4'($urandom_range(0, 15));
                bus.card_p2 = 4'($urandom_range(0, 15));
            end
            if (k == 2) bus.deal = 1'b0;
        end
        e = sb.pop_front();
        check_eq({t, ".winner"}, win_n2, e.winner);
        check_eq({t, ".err_cycles"}, err_n, e.err_n);
        check_eq({t, ".busy_cycles"}, busy_n, e.busy_n);
        check_eq({t, ".score_p1"}, s1_n3, e.s1);
        check_eq({t, ".score_p2"}, s2_n3, e.s2);
        check_eq({t, ".pot"}, int'(bus.pot), e.pot);
        check_eq({t, ".war_pending"}, int'(bus.war_pending), e.war);
        check_eq({t, ".game_over"}, int'(bus.game_over), e.over);
        $display("round %0d: cards %0d/%0d winner=%0d scores=%0d/%0d pot=%0d war=%0d over=%0d",
                 round_no, c1, c2, win_n2, bus.score_p1, bus.score_p2, bus.pot,
                 bus.war_pending, bus.game_over);
    endtask

    initial begin
        resetn      = 1'b0;
        bus.deal    = 1'b0;
        bus.card_p1 = 4'd0;
        bus.card_p2 = 4'd0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        resetn = 1'b1;

        play(9, 4);
        play(5, 5);
        play(7, 7);
        play(3, 11);

        play(6, 6);
        play(13, 2);
        play(4, 15);
        play(8, 1);

        // P1 climbs to 14, two ties build pot 3, then the saturating win.
        for (int i = 0; i < 11; i++) play(10, 0);
        play(2, 2);
        play(12, 12);
        play(11, 3);
        play(9, 4);
        play(1, 8);

        @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        model_reset();
        check_reset_outputs("reset_in_done");

        // Sixteen ties drive the pot into saturation, then P2 takes 15 in one round.
        for (int i = 0; i < 16; i++) play(2, 2);
        play(0, 1);

        @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        model_reset();
        check_reset_outputs("reset_before_award");

        @(negedge clk);
        bus.deal    = 1'b1;
        bus.card_p1 = 4'd9;
        bus.card_p2 = 4'd4;
        @(negedge clk);
        bus.deal = 1'b0;
        @(negedge clk);
        check_eq("award.busy", int'(bus.busy), 1);
        check_eq("award.winner", int'(bus.winner), 1);
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        check_reset_outputs("reset_in_award");
        $display("reset during AWARD: scores=%0d/%0d busy=%0d", bus.score_p1, bus.score_p2, bus.busy);

        play(3, 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/war_round_scorer.md
Name: war_round_scorer

Overview:
- Sequential scoring core for the War card game. Takes one card rank per player per round, compares them, and handles ties ("war") by growing a pot.
- Accumulates each player's score and flags the end of the game.
- score_p1 and score_p2 are 4-bit nibbles. Each drives one seven-segment decoder instance directly, bit 3 to x3 through bit 0 to x0.

Parameters:
- WIN_SCORE, 15: score at which a player wins. Legal range 1..15. Scores saturate here.
- MAX_RANK, 12: highest legal card rank. Ranks 0..MAX_RANK are legal; anything above is invalid.

Ports:
- clk  input  1  system clock, rising edge.
- resetn  input  1  synchronous, active-low reset.
- deal  input  1  request to play one round. Sampled only in IDLE.
- card_p1  input  4  player 1 card rank.
- card_p2  input  4  player 2 card rank.
- score_p1  output  4  player 1 score, feeds the decoder.
- score_p2  output  4  player 2 score, feeds the decoder.
- winner  output  2  last round result: 00 none, 01 P1, 10 P2, 11 tie.
- pot  output  4  points awarded to the next round winner.
- war_pending  output  1  a tie is unresolved.
- busy  output  1  FSM is not in IDLE.
- err  output  1  one-cycle pulse: an invalid card was rejected.
- game_over  output  1  a player has reached WIN_SCORE.

Behaviour:
- Reset: resetn is sampled low at a rising edge. Then state = IDLE, score_p1 = score_p2 = 0, winner = 00, pot = 1, war_pending = 0, err = 0, game_over = 0, and the card registers are cleared. Reset wins over all other activity in any state, including mid-round and DONE.
- All outputs are registered. busy is decoded from state (high in CMP, AWARD, DONE).
- States: IDLE, CMP, AWARD, DONE.
- IDLE:
  - deal = 1 at an edge latches card_p1 and card_p2, then moves to CMP.
  - deal = 0 stays in IDLE.
- CMP (one cycle):
  - Either latched card > MAX_RANK: err = 1 for exactly one cycle. Scores, pot, war_pending and winner are unchanged. Go to IDLE.
  - Cards equal: winner = 11, war_pending = 1, pot = pot + 1 saturating at 15. Go to IDLE.
  - Cards differ: winner = 01 if card_p1 is higher, else 10. Go to AWARD.
- AWARD (one cycle):
  - The winning score becomes min(score + pot, WIN_SCORE), computed at 5-bit width before saturating.
  - pot = 1, war_pending = 0.
  - Updated score == WIN_SCORE: game_over = 1, go to DONE. Otherwise go to IDLE.
- DONE: holds every output and ignores deal until reset.
- Timing: deal sampled at edge t0 (CMP follows) → winner/err update at t1 → score update at t2 → IDLE after t2. The next deal is accepted at t3 at the earliest.
- deal while busy is ignored. It is not queued. A deal held high for several cycles starts a new round each time the FSM returns to IDLE.
- Card inputs are don't-care except at the latch edge. Changes during CMP or AWARD have no effect.
- Invalid card during a war: the round is rejected, and pot and war_pending are kept.
- err is 0 in every cycle except the single error cycle.

Test Plan:
- Reset, then check idle outputs → scores 0/0, pot 1, winner 00, busy 0, game_over 0.
- deal with P1 = 9, P2 = 4 → winner 01 one edge after the deal sample, score_p1 = 1 after two edges, busy high for exactly 2 cycles.
- Ties 5/5 then 7/7, then 3/11 → pot goes 2 then 3, war_pending = 1 throughout the ties, then score_p2 += 3, pot back to 1, war_pending = 0.
- Invalid card 13 vs 2 while pot = 2 → err is a single-cycle pulse, scores unchanged, pot still 2, war_pending still 1.
- With WIN_SCORE = 15, set score_p1 = 14 and pot = 3, then P1 wins → score_p1 = 15 (saturated), game_over = 1, state DONE; further deals change nothing.
- resetn low during AWARD, and separately during DONE → all outputs return to reset values the next cycle; deal pulses during busy cycles are ignored.
